// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: bit-level I2C master running one single-byte register transaction per start pulse
module i2c_master_ctrl #(
   parameter int         CLK_DIV  = 4,
   parameter logic [6:0] DEV_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rdata,
   output logic       scl,
   output logic       sda_o,
   output logic       sda_oe,
   input  logic       sda_i
);
   localparam int DW = $clog2(CLK_DIV);
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3, S_STOP, S_DONE
   } state_t;
   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic          rw_q;
   logic [6:0]    dev_q;
   logic [7:0]    reg_q, wdata_q;
   logic [7:0]    sh_q, sh_d, rdata_q, rdata_d;
   logic          nack_q, nack_d, ack_err_q, ack_err_d;
   logic          scl_q, scl_d, sda_oe_q, sda_oe_d;
   logic          active, cap, tick, sample, bit_end, ack_slot, byte_st, drive, tx_bit;
   logic [7:0]    tx_byte;
   assign active   = state_q != S_IDLE && state_q != S_DONE;
   assign cap      = start && !active;
   assign tick     = div_q == DW'(CLK_DIV - 1);
   assign sample   = active && tick && qtr_q == 2'd2;
   assign bit_end  = active && tick && qtr_q == 2'd3;
   assign ack_slot = state_q == S_ACK1 || state_q == S_ACK2 || (state_q == S_ACK3 && !rw_q);
   assign byte_st  = state_q == S_ADDR || state_q == S_REG || state_q == S_DATA;
   assign busy     = active;
   assign done     = state_q == S_DONE;
   assign ack_err  = ack_err_q;
   assign rdata    = rdata_q;
   assign scl      = scl_q;
   assign sda_oe   = sda_oe_q;
   assign sda_o    = 1'b0;
   // State register: FSM, quarter/bit timing, captured request and registered bus outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         div_q     <= '0;
         qtr_q     <= 2'd0;
         bit_q     <= 3'd0;
         rw_q      <= 1'b0;
         dev_q     <= DEV_ADDR;
         reg_q     <= 8'd0;
         wdata_q   <= 8'd0;
         sh_q      <= 8'd0;
         rdata_q   <= 8'd0;
         nack_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         rdata_q   <= rdata_d;
         nack_q    <= nack_d;
         ack_err_q <= ack_err_d;
         scl_q     <= scl_d;
         sda_oe_q  <= sda_oe_d;
         if (cap) begin
            rw_q    <= rw;
            dev_q   <= dev_addr;
            reg_q   <= reg_addr;
            wdata_q <= wdata;
         end
      end
   end
   // Next state: bit sequencing, ACK sampling, read shifting and completion status
   always_comb begin
      state_d   = state_q;
      div_d     = active ? (tick ? '0 : div_q + 1'b1) : '0;
      qtr_d     = active ? qtr_q + {1'b0, tick} : 2'd0;
      bit_d     = (bit_end && byte_st) ? bit_q + 3'd1 : bit_q;
      sh_d      = (sample && state_q == S_DATA && rw_q) ? {sh_q[6:0], sda_i} : sh_q;
      nack_d    = cap ? 1'b0 : nack_q | (sample && ack_slot && sda_i);
      ack_err_d = cap ? 1'b0 : ack_err_q;
      rdata_d   = rdata_q;
      case (state_q)
         S_IDLE:  state_d = cap ? S_START : S_IDLE;
         S_START: state_d = bit_end ? S_ADDR : S_START;
         S_ADDR:  state_d = (bit_end && bit_q == 3'd7) ? S_ACK1 : S_ADDR;
         S_ACK1:  state_d = bit_end ? (nack_q ? S_STOP : S_REG) : S_ACK1;
         S_REG:   state_d = (bit_end && bit_q == 3'd7) ? S_ACK2 : S_REG;
         S_ACK2:  state_d = bit_end ? (nack_q ? S_STOP : S_DATA) : S_ACK2;
         S_DATA:  state_d = (bit_end && bit_q == 3'd7) ? S_ACK3 : S_DATA;
         S_ACK3:  state_d = bit_end ? S_STOP : S_ACK3;
         S_STOP: begin
            state_d   = bit_end ? S_DONE : S_STOP;
            ack_err_d = bit_end ? nack_q : ack_err_q;
            rdata_d   = (bit_end && rw_q && !nack_q) ? sh_q : rdata_q;
         end
         S_DONE:  state_d = cap ? S_START : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   // Bus outputs: scl follows the upcoming quarter, sda trails it by one clk so the two never move together
   always_comb begin
      tx_byte  = state_q == S_ADDR ? {dev_q, rw_q} : state_q == S_REG ? reg_q : wdata_q;
      tx_bit   = tx_byte[~bit_q];
      drive    = state_q == S_ADDR || state_q == S_REG || (state_q == S_DATA && !rw_q);
      sda_oe_d = state_q == S_START ? qtr_q[1] : state_q == S_STOP ? qtr_q != 2'd3 : drive && !tx_bit;
      scl_d    = (state_d == S_IDLE || state_d == S_START || state_d == S_DONE) ? 1'b1 : qtr_d[1];
   end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: randomized scoreboard bench with a bus-level slave and protocol monitor
module tb_i2c_master_ctrl;
   localparam int CLK_DIV = 4;
   localparam int BT = 4 * CLK_DIV;
   typedef struct {
      int         t;
      bit         err;
      logic [7:0] rd;
      int         nb;
      logic [7:0] b0, b1, b2;
   } exp_t;
   logic clk = 0, rst = 1, start = 0, rw = 0;
   logic [6:0] dev_addr = 0;
   logic [7:0] reg_addr = 0, wdata = 0;
   logic busy, done, ack_err, scl, sda_o, sda_oe;
   logic [7:0] rdata;
   logic slv_drv = 0;
   logic sda_bus;
   assign sda_bus = ~(sda_oe | slv_drv);
   i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h50)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
      .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
      .ack_err(ack_err), .rdata(rdata), .scl(scl), .sda_o(sda_o),
      .sda_oe(sda_oe), .sda_i(sda_bus)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   exp_t sb[$];
   int n_chk = 0, n_fail = 0;
   logic nack_a = 0, nack_r = 0, nack_d = 0;
   logic [7:0] rbyte = 0, rd_model = 0;
   int idle_req = 0, clr_req = 0;
   bit idle_full = 0, fin_req = 0, fin_ack = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask
   function automatic logic [7:0] byte_at(input logic [31:0] b, input int o);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = b[o+i];
      return r;
   endfunction
   // Monitor: bus decoder, slave responder, protocol checker and scoreboard comparisons
   logic prev_scl = 1, prev_sda = 1, in_tx = 0, stop_seen = 0, scl_now, sda_now;
   logic [31:0] bb = 0;
   int nb = 0, idle_ack = 0, clr_ack = 0;
   exp_t e;
   initial forever begin
      @(negedge clk);
      scl_now = scl;
      sda_now = sda_bus;
      if (clr_req != clr_ack) begin
         clr_ack = clr_req;
         in_tx = 0;
         nb = 0;
         stop_seen = 0;
         slv_drv = 0;
      end
      if (idle_req != idle_ack) begin
         idle_ack = idle_req;
         chk("idle_scl", scl, 1);
         chk("idle_sda_oe", sda_oe, 0);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_sda_o", sda_o, 0);
         if (idle_full) begin
            chk("reset_ack_err", ack_err, 0);
            chk("reset_rdata", rdata, 0);
         end
      end
      if (fin_req && !fin_ack) begin
         chk("scoreboard_empty", sb.size(), 0);
         fin_ack = 1;
      end
      if (!rst) begin
         if (prev_scl && scl_now && prev_sda != sda_now) begin
            if (!sda_now) begin
               chk("start_outside_tx", in_tx, 0);
               in_tx = 1;
               nb = 0;
               stop_seen = 0;
            end else begin
               chk("stop_inside_tx", in_tx, 1);
               in_tx = 0;
               stop_seen = 1;
            end
         end
         if (!prev_scl && scl_now && in_tx) begin
            bb[nb] = sda_now;
            if (nb < 31) nb++;
         end
         if (prev_scl && !scl_now && in_tx)
            slv_drv = (nb == 8 && !nack_a) || (nb == 17 && !nack_r) ||
                      (bb[7] && nb >= 18 && nb <= 25 && !rbyte[3'(25 - nb)]) ||
                      (!bb[7] && nb == 26 && !nack_d);
         if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               chk("done_cycle", cyc, e.t);
               chk("busy_at_done", busy, 0);
               chk("ack_err", ack_err, {31'd0, e.err});
               chk("rdata", rdata, e.rd);
               chk("bus_bit_count", nb, e.nb);
               chk("stop_seen", stop_seen, 1);
               chk("addr_byte", byte_at(bb, 0), e.b0);
               if (e.nb >= 19) chk("reg_byte", byte_at(bb, 9), e.b1);
               if (e.nb == 28) chk("data_byte", byte_at(bb, 18), e.b2);
            end
         end
         if (sb.size() > 0 && cyc > sb[0].t + 50) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
         end
      end
      prev_scl = scl_now;
      prev_sda = sda_now;
   end
   task automatic issue(input bit r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd,
                        input logic [7:0] rb, input bit na, input bit nr, input bit nd);
      exp_t x;
      int bits;
      @(negedge clk);
      rw = r;
      dev_addr = d;
      reg_addr = ra;
      wdata = wd;
      rbyte = rb;
      nack_a = na;
      nack_r = !na && nr;
      nack_d = nd;
      start = 1;
      bits = na ? 11 : nack_r ? 20 : 29;
      x.t = cyc + 1 + bits * BT;
      x.nb = bits - 1;
      x.err = na || nack_r || (!r && nd);
      x.rd = (r && !x.err) ? rb : rd_model;
      rd_model = x.rd;
      x.b0 = {d, r};
      x.b1 = ra;
      x.b2 = r ? rb : wd;
      sb.push_back(x);
      @(negedge clk);
      start = 0;
      rw = 1'($urandom);
      dev_addr = 7'($urandom);
      reg_addr = 8'($urandom);
      wdata = 8'($urandom);
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 1500 && (sb.size() != 0 || busy); i++) @(negedge clk);
      repeat (5) @(negedge clk);
   endtask
   task automatic pulse_busy_start();
      @(negedge clk);
      rw = 1'($urandom);
      dev_addr = 7'($urandom);
      reg_addr = 8'($urandom);
      wdata = 8'($urandom);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      idle_full = 1;
      idle_req++;
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      idle_req++;
      repeat (3) @(negedge clk);
      idle_full = 0;
      issue(0, 7'h50, 8'h25, 8'hA5, 8'h00, 0, 0, 0);
      wait_idle();
      issue(1, 7'h50, 8'h25, 8'h00, 8'h10, 0, 0, 0);
      wait_idle();
      issue(1, 7'h50, 8'h33, 8'h00, 8'h77, 1, 0, 0);
      wait_idle();
      issue(0, 7'h50, 8'h40, 8'h3C, 8'h00, 0, 1, 0);
      wait_idle();
      issue(0, 7'h2A, 8'h81, 8'h5A, 8'h00, 0, 0, 1);
      wait_idle();
      issue(0, 7'h13, 8'hC4, 8'h96, 8'h00, 0, 0, 0);
      repeat (200) @(negedge clk);
      pulse_busy_start();
      repeat (150) @(negedge clk);
      pulse_busy_start();
      wait_idle();
      idle_req++;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         issue(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
         wait_idle();
      end
      issue(0, 7'h50, 8'h25, 8'hFF, 8'h00, 0, 0, 0);
      repeat (99) @(negedge clk);
      rst = 1;
      sb.delete();
      rd_model = 0;
      clr_req++;
      @(negedge clk);
      idle_full = 1;
      idle_req++;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      idle_req++;
      repeat (600) @(negedge clk);
      idle_full = 0;
      issue(1, 7'h50, 8'h25, 8'h00, 8'hC3, 0, 0, 0);
      wait_idle();
      fin_req = 1;
      for (int i = 0; i < 10 && !fin_ack; i++) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
